ddr3_app_arbiter: RTL and testbench

DDR3_APP_ARBITER -- requirements
Module: ddr3_app_arbiter

---
 rtl/ddr3_pkg.sv | 16 +
 rtl/ddr3_app_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ddr3_app_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// Shared command codes, arbiter state type and default bus widths for the
// DDR3 MIG application-port arbiter.
package ddr3_pkg;

   localparam int unsigned DEF_ADDR_W = 27;
   localparam int unsigned DEF_DATA_W = 128;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   // Consecutive read grants allowed while a write is left waiting.
   localparam int unsigned STARVE_LIMIT = 8;

   typedef enum logic [1:0] {StInit, StIdle, StWr, StRd} arb_state_t;

endpackage

// File: rtl/ddr3_app_arbiter.sv
// Two-requester arbiter (SD-loader writes, HDMI-fetch reads) onto the MIG app
// interface, with an outstanding-read limit and write anti-starvation.
module ddr3_app_arbiter
   import ddr3_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned MAX_RD = 8
) (
   input  logic              clk_ref_i,
   input  logic              reset_rtl_0,
   input  logic              init_calib_complete,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              app_rd_data_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ack,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid
);

   localparam int unsigned CntW = $clog2(MAX_RD + 1);
   localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

   arb_state_t        state_q, state_d;
   logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [StvW-1:0]   starve_q, starve_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        cmd_q, cmd_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              en_q, en_d;
   logic              wren_q, wren_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_ack_q, rd_ack_d;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;

   logic cmd_acc, wdf_acc, rd_accept;

   assign cmd_acc = en_q & app_rdy;
   assign wdf_acc = wren_q & app_wdf_rdy;

   always_comb begin
      state_d   = state_q;
      starve_d  = starve_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      wdata_d   = wdata_q;
      en_d      = en_q;
      wren_d    = wren_q;
      wr_ack_d  = 1'b0;
      rd_ack_d  = 1'b0;
      rd_accept = 1'b0;

      unique case (state_q)
         StInit: begin
            if (init_calib_complete) state_d = StIdle;
         end
         StIdle: begin
            if (!init_calib_complete) begin
               state_d = StInit;
            end else if (rd_req && (rd_cnt_q < CntW'(MAX_RD)) &&
                         (starve_q != StvW'(STARVE_LIMIT))) begin
               state_d = StRd;
               addr_d  = rd_addr;
               cmd_d   = CMD_READ;
               en_d    = 1'b1;
               // Below the limit here, so the increment cannot pass it.
               if (wr_req) starve_d = starve_q + StvW'(1);
            end else if (wr_req) begin
               state_d  = StWr;
               addr_d   = wr_addr;
               cmd_d    = CMD_WRITE;
               wdata_d  = wr_data;
               en_d     = 1'b1;
               wren_d   = 1'b1;
               starve_d = '0;
            end
         end
         StWr: begin
            if (cmd_acc) en_d = 1'b0;
            if (wdf_acc) wren_d = 1'b0;
            // Command and data beat may be taken on different edges, in either order.
            if ((cmd_acc || !en_q) && (wdf_acc || !wren_q)) begin
               wr_ack_d = 1'b1;
               state_d  = StIdle;
            end
         end
         StRd: begin
            if (cmd_acc) begin
               en_d      = 1'b0;
               rd_ack_d  = 1'b1;
               rd_accept = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StInit;
      endcase
   end

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      case ({rd_accept, app_rd_data_valid})
         2'b10:   rd_cnt_d = rd_cnt_q + CntW'(1);
         2'b01:   if (rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - CntW'(1);
         default: rd_cnt_d = rd_cnt_q;
      endcase
   end

   always_ff @(posedge clk_ref_i or posedge reset_rtl_0) begin
      if (reset_rtl_0) begin
         state_q    <= StInit;
         rd_cnt_q   <= '0;
         starve_q   <= '0;
         addr_q     <= '0;
         cmd_q      <= CMD_WRITE;
         wdata_q    <= '0;
         en_q       <= 1'b0;
         wren_q     <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         cmd_q      <= cmd_d;
         wdata_q    <= wdata_d;
         en_q       <= en_d;
         wren_q     <= wren_d;
         wr_ack_q   <= wr_ack_d;
         rd_ack_q   <= rd_ack_d;
         rd_data_q  <= app_rd_data;
         rd_valid_q <= app_rd_data_valid;
      end
   end

   assign app_addr     = addr_q;
   assign app_cmd      = cmd_q;
   assign app_en       = en_q;
   assign app_wdf_data = wdata_q;
   assign app_wdf_wren = wren_q;
   assign app_wdf_end  = wren_q;
   assign wr_ack       = wr_ack_q;
   assign rd_ack       = rd_ack_q;
   assign rd_data      = rd_data_q;
   assign rd_valid     = rd_valid_q;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Scoreboard bench for ddr3_app_arbiter: a transaction-level arbitration model
// predicts grants and handshake timing; a monitor checks what the DUT presents.
module tb_ddr3_app_arbiter;
   import ddr3_pkg::*;

   localparam int unsigned AW = 27;
   localparam int unsigned DW = 128;
   localparam int MAXRD = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          calib;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en, app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;
   logic          wr_req, wr_ack, rd_req, rd_ack, rd_valid;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [DW-1:0] wr_data, rd_data;

   always #5 clk = ~clk;

   ddr3_app_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_RD(MAXRD)) dut (
      .clk_ref_i(clk), .reset_rtl_0(rst), .init_calib_complete(calib),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
      .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   typedef struct {
      logic [2:0]    cmd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int            due;
   } cmd_t;
   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } rdd_t;

   cmd_t cmd_q[$];
   rdd_t rd_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction
   function automatic logic [AW-1:0] rnd_addr();
      logic [31:0] r;
      r = $urandom;
      return r[AW-1:0];
   endfunction

   // ---------------- reference model (arbitration rules at transaction level)
   bit m_ready, m_en, m_wren, m_wack, m_rack, nwack, nrack;
   int m_kind;   // 0 none in progress, 1 write, 2 read
   int m_out, m_starve, ret_inc;
   cmd_t mc;

   always @(negedge clk) begin
      if (rst) begin
         m_ready = 0; m_kind = 0; m_en = 0; m_wren = 0; m_wack = 0; m_rack = 0;
         m_out = 0; m_starve = 0;
         cmd_q.delete();
      end else begin
         chk("app_en", app_en, m_en);
         chk("app_wdf_wren", app_wdf_wren, m_wren);
         chk("app_wdf_end", app_wdf_end, m_wren);
         chk("wr_ack", wr_ack, m_wack);
         chk("rd_ack", rd_ack, m_rack);
         nwack = 0; nrack = 0;
         if (m_kind == 1) begin
            if (m_en && app_rdy) m_en = 0;
            if (m_wren && app_wdf_rdy) m_wren = 0;
            if (!m_en && !m_wren) begin m_kind = 0; nwack = 1; end
         end else if (m_kind == 2) begin
            if (app_rdy) begin m_en = 0; m_kind = 0; nrack = 1; m_out++; ret_inc++; end
         end else if (!m_ready) begin
            if (calib) m_ready = 1;
         end else if (!calib) begin
            m_ready = 0;
         end else if (rd_req && m_out < MAXRD && m_starve < 8) begin
            mc.cmd = CMD_READ; mc.addr = rd_addr; mc.data = '0; mc.due = cyc + 1;
            cmd_q.push_back(mc);
            if (wr_req) m_starve++;
            m_kind = 2; m_en = 1;
         end else if (wr_req) begin
            mc.cmd = CMD_WRITE; mc.addr = wr_addr; mc.data = wr_data; mc.due = cyc + 1;
            cmd_q.push_back(mc);
            m_starve = 0; m_kind = 1; m_en = 1; m_wren = 1;
         end
         if (app_rd_data_valid && m_out > 0) m_out--;
         m_wack = nwack; m_rack = nrack;
      end
   end

   // ---------------- monitor: pops expectations when the DUT presents output
   bit   en_prev, stv_on, stv_seen;
   int   stv_run;
   cmd_t pc;
   rdd_t pr;

   always @(negedge clk) begin
      if (rst) begin
         en_prev = 0;
      end else begin
         if (app_en && !en_prev) begin
            if (cmd_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_cmd: got cmd %0h addr %0h, none expected", app_cmd,
                        app_addr);
            end else begin
               pc = cmd_q.pop_front();
               chk("cmd_cycle", cyc, pc.due);
               chk("app_cmd", app_cmd, pc.cmd);
               chk("app_addr", app_addr, pc.addr);
               if (pc.cmd == CMD_WRITE) chk("app_wdf_data", app_wdf_data, pc.data);
               if (stv_on) begin
                  if (pc.cmd == CMD_READ) stv_run++;
                  else begin
                     if (stv_seen) chk("reads_before_write", stv_run, 8);
                     stv_seen = 1; stv_run = 0;
                  end
               end
            end
         end
         en_prev = app_en;
         if (!stv_on) begin stv_seen = 0; stv_run = 0; end
         if (rd_valid) begin
            if (rd_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_rd_valid: got data %0h, none expected", rd_data);
            end else begin
               pr = rd_q.pop_front();
               chk("rd_valid_cycle", cyc, pr.due);
               chk("rd_data", rd_data, pr.data);
            end
         end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            pr = rd_q.pop_front();
            n_vec++; n_err++;
            $display("FAIL missing_rd_valid: got none, required data %0h at cycle %0d",
                     pr.data, pr.due);
         end
      end
   end

   // ---------------- stimulus: requesters and MIG behaviour
   int  wr_pct, rd_pct, ret_pct, ret_dec, cnt, cal_hold;
   bit  ret_one;
   rdd_t rq;

   task automatic step();
      @(posedge clk);
      #1;
      if (wr_req && wr_ack) wr_req = 0;
      if (!wr_req && $urandom_range(0, 99) < wr_pct) begin
         wr_req = 1; wr_addr = rnd_addr(); wr_data = rnd_data();
      end
      if (rd_req && rd_ack) rd_req = 0;
      if (!rd_req && $urandom_range(0, 99) < rd_pct) begin
         rd_req = 1; rd_addr = rnd_addr();
      end
      app_rd_data_valid = 0;
      app_rd_data = rnd_data();
      if (ret_inc > ret_dec && (ret_one || $urandom_range(0, 99) < ret_pct)) begin
         app_rd_data_valid = 1;
         ret_dec++;
         ret_one = 0;
         rq.data = app_rd_data; rq.due = cyc + 1;
         rd_q.push_back(rq);
      end
   endtask

   initial begin
      rst = 1; calib = 0; app_rdy = 0; app_wdf_rdy = 0;
      app_rd_data = '0; app_rd_data_valid = 0;
      wr_req = 0; wr_addr = '0; wr_data = '0; rd_req = 0; rd_addr = '0;
      wr_pct = 0; rd_pct = 0; ret_pct = 0; ret_dec = 0; ret_one = 0; stv_on = 0; cal_hold = 0;
      repeat (3) step();
      chk("rst_app_en", app_en, 0);
      chk("rst_app_cmd", app_cmd, 3'b000);
      chk("rst_app_addr", app_addr, 0);
      chk("rst_wdf_data", app_wdf_data, 0);
      chk("rst_rd_valid", rd_valid, 0);
      rst = 0;

      // Calibration gate with a write pending.
      wr_pct = 100; app_rdy = 1; app_wdf_rdy = 1;
      repeat (50) step();
      calib = 1;
      step(); chk("calib_plus1_app_en", app_en, 0);
      step(); chk("calib_plus2_app_en", app_en, 1); chk("calib_app_cmd", app_cmd, CMD_WRITE);
      wr_pct = 0; repeat (10) step();

      // Split write handshake: data beat at once, command 5 cycles late.
      app_rdy = 0; app_wdf_rdy = 1; wr_pct = 100; step(); wr_pct = 0;
      cnt = 0;
      for (int i = 0; i < 14; i++) begin
         step();
         if (i == 5) app_rdy = 1;
         if (wr_ack) cnt++;
      end
      chk("split_wr_ack_count", cnt, 1);

      // Starvation pattern with both requesters saturated.
      ret_pct = 100; stv_on = 1; wr_pct = 100; rd_pct = 100;
      repeat (100) step();
      wr_pct = 0; rd_pct = 0; stv_on = 0;
      repeat (20) step();

      // Outstanding-read limit.
      ret_pct = 0; rd_pct = 100; cnt = 0;
      repeat (40) begin step(); if (rd_ack) cnt++; end
      chk("rd_acks_at_limit", cnt, 8);
      ret_one = 1; cnt = 0;
      repeat (20) begin step(); if (rd_ack) cnt++; end
      chk("rd_acks_after_one_return", cnt, 1);

      // Read accept and returned data on the same edge.
      app_rdy = 0; ret_one = 1; step();
      repeat (3) step();
      ret_one = 1; step(); app_rdy = 1;
      cnt = 0;
      repeat (15) begin step(); if (rd_ack) cnt++; end
      chk("rd_acks_coincident", cnt, 2);
      rd_pct = 0; ret_pct = 100; repeat (30) step();

      // Randomised traffic with MIG back-pressure and calibration drops.
      wr_pct = 30; rd_pct = 40; ret_pct = 40;
      for (int i = 0; i < 1500; i++) begin
         step();
         app_rdy = ($urandom_range(0, 99) < 70);
         app_wdf_rdy = ($urandom_range(0, 99) < 70);
         if (cal_hold > 0) begin
            cal_hold--;
            if (cal_hold == 0) calib = 1;
         end else if ($urandom_range(0, 199) == 0) begin
            calib = 0; cal_hold = $urandom_range(1, 6);
         end
      end
      calib = 1; wr_pct = 0; rd_pct = 0; ret_pct = 100; app_rdy = 1; app_wdf_rdy = 1;
      repeat (40) step();

      // Reset in the middle of a write.
      ret_pct = 0; app_rdy = 0; app_wdf_rdy = 0; wr_pct = 100; step(); wr_pct = 0;
      repeat (3) step();
      chk("pre_reset_app_en", app_en, 1);
      #2 rst = 1;
      #1;
      chk("reset_app_en", app_en, 0);
      chk("reset_app_wdf_wren", app_wdf_wren, 0);
      chk("reset_app_wdf_end", app_wdf_end, 0);
      chk("reset_app_cmd", app_cmd, 3'b000);
      chk("reset_app_addr", app_addr, 0);
      chk("reset_app_wdf_data", app_wdf_data, 0);
      chk("reset_wr_ack", wr_ack, 0);
      rd_q.delete(); ret_dec = ret_inc;
      step(); step();
      rst = 0; app_rdy = 1; app_wdf_rdy = 1; cnt = 0;
      repeat (10) begin step(); if (wr_ack) cnt++; end
      chk("wr_acks_after_reset", cnt, 1);

      repeat (5) step();
      chk("cmd_queue_drained", cmd_q.size(), 0);
      chk("rd_queue_drained", rd_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
